data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data RAM between the pipeline MEM stage (CPU port) and an external
//  loader/debug port (EXT port). CPU has priority; a starvation counter forces one EXT slot
//  after MAX_WAIT blocked cycles and raises cpu_stall, which freezes PC, IF/ID, ID/EX, EX/MEM.
//  Sits between EX/MEM outputs and the RAM instance; cpu_rdata feeds MEM/WB unchanged.
// PARAMETERS
//  DATA_W    32    RAM word width
//  ADDR_W    10    RAM address width
//  DEPTH     1024  valid words; EXT addresses >= DEPTH are errors
//  MAX_WAIT  4     consecutive blocked EXT cycles before a forced EXT slot (>=1)
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  cpu_req    in   1       MemRead|MemWrite from EX/MEM
//  cpu_we     in   1       MemWrite from EX/MEM
//  cpu_addr   in   ADDR_W  ALU result from EX/MEM
//  cpu_wdata  in   DATA_W  readData2 from EX/MEM
//  cpu_rdata  out  DATA_W  read data to MEM/WB
//  cpu_stall  out  1       freeze pipeline this cycle
//  ext_req    in   1       EXT access request, held until ext_gnt
//  ext_we     in   1       EXT write
//  ext_addr   in   ADDR_W  EXT address
//  ext_wdata  in   DATA_W  EXT write data
//  ext_gnt    out  1       EXT access performed this cycle
//  ext_rvalid out  1       ext_rdata valid (cycle after granted EXT read)
//  ext_rdata  out  DATA_W  EXT read data (registered)
//  ext_err    out  1       with ext_rvalid: granted access was out of range
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM address
//  ram_din    out  DATA_W  RAM write data
//  ram_dout   in   DATA_W  RAM read data, 1-cycle latency
// BEHAVIOUR
//  Reset: state=S_CPU, wait_cnt=0, ext_rvalid=0, ext_err=0, ext_rdata=0; cpu_stall=0, ext_gnt=0.
//  S_CPU, cpu_req=1: RAM driven by CPU; ext_gnt=0; if ext_req, wait_cnt++.
//  S_CPU, cpu_req=0, ext_req=1: RAM driven by EXT same cycle, ext_gnt=1, wait_cnt<=0.
//  S_CPU, no requests: ram_we=0, ram_addr=cpu_addr; wait_cnt<=0 if !ext_req.
//  S_CPU->S_FORCE when cpu_req & ext_req & wait_cnt==MAX_WAIT-1 (the MAX_WAIT-th blocked cycle).
//  S_FORCE (exactly one cycle): cpu_stall=1, RAM driven by EXT, ext_gnt=ext_req, wait_cnt<=0;
//   always returns to S_CPU. If ext_req dropped: stall still issued, ram_we=0.
//  cpu_stall is 0 in S_CPU; stalled CPU request re-presents identical signals next cycle.
//  ram_we = granted_we & in-range; EXT write with ext_addr>=DEPTH is dropped.
//  ext_rvalid<=1 cycle after any ext_gnt (read or write); ext_rdata<=ram_dout for reads, held else.
//  ext_err<=1 with that ext_rvalid iff the granted ext_addr>=DEPTH; otherwise 0.
//  cpu_rdata = ram_dout (pass-through, same timing as direct RAM connection).
//  Reset asserted mid-access: all state cleared immediately, ram_we forced 0 while rst_n=0.
//  wait_cnt saturates at MAX_WAIT-1; never wraps.
// STRUCTURE
//  Shared include pipeline_defs.vh: DATA_W, ADDR_W, state encodings S_CPU/S_FORCE.
//  One sub-module: starvation_counter (inc/clear/saturate, flag at MAX_WAIT-1).
//  Remainder: FSM, RAM-port mux, EXT read-return register.
// TESTING
//  1 Reset: rst_n=0 mid-S_FORCE -> cpu_stall=0, ext_rvalid=0, ram_we=0 immediately.
//  2 Idle CPU: ext read 0x010 holding 0xCAFE0001 -> ext_gnt same cycle, next cycle rvalid, rdata=0xCAFE0001.
//  3 Starvation: cpu_req=1 continuous, ext write 0x020=0x55 -> gnt on cycle 5, cpu_stall=1 exactly cycle 5.
//  4 CPU repeat after force: CPU write 0x030=0x77 stalled -> completes next cycle; both 0x020, 0x030 correct.
//  5 Out of range (DEPTH=512): ext write 0x3FF -> ram_we=0, next cycle ext_rvalid=1, ext_err=1.
//  6 EXT drop in S_FORCE: ext_req falls in force cycle -> cpu_stall=1, ext_gnt=0, ram_we=0, no rvalid.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared widths and FSM state encodings for the data RAM arbiter
package data_mem_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    // Two-state arbiter: normal CPU-priority operation, and the single forced EXT slot.
    localparam logic [0:0] S_CPU   = 1'b0;
    localparam logic [0:0] S_FORCE = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_starvation_counter.sv
// rtl/data_mem_arbiter_starvation_counter.sv - counts consecutive blocked EXT cycles, flags MAX_WAIT-1
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_inc           EXT blocked by CPU this cycle
//   i_clr           restart the count (takes priority over i_inc)
//   o_at_max        count has reached MAX_WAIT-1 (this blocked cycle is the MAX_WAIT-th)
module starvation_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at LIMIT rather than wrapping, so a held flag can never alias back to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == LIMIT);

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the single-port data RAM between the MEM stage and an EXT port
//
// Ports:
//   i_clk, i_rst_n                                   clock, asynchronous active-low reset
//   i_cpu_req/i_cpu_we/i_cpu_addr/i_cpu_wdata        MEM-stage access from EX/MEM
//   o_cpu_rdata                                      RAM read data to MEM/WB (pass-through)
//   o_cpu_stall                                      freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   i_ext_req/i_ext_we/i_ext_addr/i_ext_wdata        loader/debug access, held until o_ext_gnt
//   o_ext_gnt                                        EXT access performed this cycle
//   o_ext_rvalid/o_ext_rdata/o_ext_err               EXT completion, cycle after the grant
//   o_ram_we/o_ram_addr/o_ram_din/i_ram_dout         RAM port, 1-cycle read latency
import data_mem_arbiter_pkg::*;

module data_mem_arbiter #(
    parameter int DATA_W   = data_mem_arbiter_pkg::DATA_W,
    parameter int ADDR_W   = data_mem_arbiter_pkg::ADDR_W,
    parameter int DEPTH    = 1024,
    parameter int MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_stall,
    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [DATA_W-1:0] i_ext_wdata,
    output logic              o_ext_gnt,
    output logic              o_ext_rvalid,
    output logic [DATA_W-1:0] o_ext_rdata,
    output logic              o_ext_err,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout
);

    localparam int          CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        r_state;
    logic              r_ext_rvalid;
    logic              r_ext_err;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_ext_rdata;

    logic [0:0]        w_next_state;
    logic              w_ext_in_range;
    logic              w_cpu_in_range;
    logic              w_blocked;
    logic              w_at_max;
    logic              w_gnt_raw;
    logic              w_we_raw;
    logic              w_stall_raw;
    logic [DATA_W-1:0] w_ext_rdata;

    assign w_ext_in_range = ({1'b0, i_ext_addr} < DEPTH_L);
    assign w_cpu_in_range = ({1'b0, i_cpu_addr} < DEPTH_L);

    // EXT is blocked only when both sides want the RAM in normal operation; any other
    // cycle breaks the run of consecutive blocked cycles.
    assign w_blocked = (r_state == S_CPU) && i_cpu_req && i_ext_req;

    starvation_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_starve (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_inc    (w_blocked),
        .i_clr    (!w_blocked),
        .o_at_max (w_at_max)
    );

    always_comb begin
        w_next_state = S_CPU;
        w_gnt_raw    = 1'b0;
        w_we_raw     = 1'b0;
        w_stall_raw  = 1'b0;
        o_ram_addr   = i_cpu_addr;
        o_ram_din    = i_cpu_wdata;
        case (r_state)
            S_CPU: begin
                if (i_cpu_req) begin
                    w_we_raw = i_cpu_we && w_cpu_in_range;
                    if (w_blocked && w_at_max) begin
                        w_next_state = S_FORCE;
                    end
                end else if (i_ext_req) begin
                    o_ram_addr = i_ext_addr;
                    o_ram_din  = i_ext_wdata;
                    w_gnt_raw  = 1'b1;
                    w_we_raw   = i_ext_we && w_ext_in_range;
                end
            end
            S_FORCE: begin
                // The stall is issued even if EXT withdrew; the slot then idles the RAM.
                w_stall_raw = 1'b1;
                o_ram_addr  = i_ext_addr;
                o_ram_din   = i_ext_wdata;
                w_gnt_raw   = i_ext_req;
                w_we_raw    = i_ext_req && i_ext_we && w_ext_in_range;
            end
            default: begin
                w_next_state = S_CPU;
            end
        endcase
    end

    // Reset must silence the RAM and handshakes at once, not at the next edge.
    assign o_ram_we    = w_we_raw && i_rst_n;
    assign o_ext_gnt   = w_gnt_raw && i_rst_n;
    assign o_cpu_stall = w_stall_raw && i_rst_n;

    assign o_cpu_rdata = i_ram_dout;

    // RAM data for an EXT read arrives the cycle after the grant; expose it directly
    // then and hold it in r_ext_rdata until the next EXT read returns.
    assign w_ext_rdata = r_rd_pend ? i_ram_dout : r_ext_rdata;
    assign o_ext_rdata = w_ext_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_CPU;
            r_ext_rvalid <= 1'b0;
            r_ext_err    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_ext_rdata  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_ext_rvalid <= o_ext_gnt;
            r_ext_err    <= o_ext_gnt && !w_ext_in_range;
            r_rd_pend    <= o_ext_gnt && !i_ext_we && w_ext_in_range;
            r_ext_rdata  <= w_ext_rdata;
        end
    end

    assign o_ext_rvalid = r_ext_rvalid;
    assign o_ext_err    = r_ext_err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter with a behavioural RAM
module tb_data_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          ext_gnt, ext_rvalid, ext_err;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .MAX_WAIT (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_stall  (cpu_stall),
        .i_ext_req    (ext_req),
        .i_ext_we     (ext_we),
        .i_ext_addr   (ext_addr),
        .i_ext_wdata  (ext_wdata),
        .o_ext_gnt    (ext_gnt),
        .o_ext_rvalid (ext_rvalid),
        .o_ext_rdata  (ext_rdata),
        .o_ext_err    (ext_err),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_din    (ram_din),
        .i_ram_dout   (ram_dout)
    );

    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW:0]   sb_q [$];
    logic [DW-1:0] exp_mem [int];
    logic [DW-1:0] hold;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic pop_chk(input string tag);
        logic [DW:0] e;
        chk({tag, "_rvalid"}, 32'(ext_rvalid), 32'd1);
        n_vec++;
        assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_err"}, 32'(ext_err), 32'(e[DW]));
            chk({tag, "_rdata"}, ext_rdata, e[DW-1:0]);
        end
    endtask

    // Expected completion for an EXT access, pushed when the access is granted.
    task automatic sb_push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic oor;
        oor = (int'(addr) >= DEPTH);
        if (oor) begin
            sb_q.push_back({1'b1, hold});
        end else if (we) begin
            exp_mem[int'(addr)] = data;
            sb_q.push_back({1'b0, hold});
        end else begin
            hold = exp_mem[int'(addr)];
            sb_q.push_back({1'b0, hold});
        end
    endtask

    // One EXT access with the CPU idle: granted the same cycle, completion the next.
    task automatic ext_single(input string tag, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data);
        ext_req = 1; ext_we = we; ext_addr = addr; ext_wdata = data;
        #1;
        chk({tag, "_gnt"}, 32'(ext_gnt), 32'd1);
        chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'(we && (int'(addr) < DEPTH)));
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(addr));
        sb_push(we, addr, data);
        @(negedge clk);
        ext_req = 0;
        #1;
        chk({tag, "_gnt_off"}, 32'(ext_gnt), 32'd0);
        pop_chk(tag);
        @(negedge clk);
    endtask

    // Block EXT behind a continuous CPU read for MAX_WAIT cycles; returns in the forced cycle.
    task automatic starve(input string tag, input logic [AW-1:0] eaddr, input logic [DW-1:0] edata);
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        ext_req = 1; ext_we = 1; ext_addr = eaddr; ext_wdata = edata;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("%s_blk%0d_gnt", tag, i), 32'(ext_gnt), 32'd0);
            chk($sformatf("%s_blk%0d_stall", tag, i), 32'(cpu_stall), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        hold = '0;
        idle_all();
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_gnt", 32'(ext_gnt), 32'd0);
        chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
        chk("rst_err", 32'(ext_err), 32'd0);
        chk("rst_rdata", ext_rdata, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Idle CPU: EXT load then read-back.
        ext_single("ld10", 1'b1, 10'h010, 32'hCAFE0001);
        ext_single("rd10", 1'b0, 10'h010, 32'h0);

        // CPU read pass-through.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        #1;
        chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        chk("cpu_rd_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        cpu_req = 0;
        #1;
        chk("cpu_rdata", cpu_rdata, 32'hCAFE0001);
        @(negedge clk);

        // Starvation: forced EXT write on the 5th cycle, CPU write stalled there.
        starve("st", 10'h020, 32'h55);
        cpu_we = 1; cpu_addr = 10'h030; cpu_wdata = 32'h77;
        #1;
        chk("force_gnt", 32'(ext_gnt), 32'd1);
        chk("force_stall", 32'(cpu_stall), 32'd1);
        chk("force_ram_we", 32'(ram_we), 32'd1);
        chk("force_ram_addr", 32'(ram_addr), 32'h020);
        chk("force_ram_din", ram_din, 32'h55);
        sb_push(1'b1, 10'h020, 32'h55);
        @(negedge clk);
        ext_req = 0;
        #1;
        chk("after_stall", 32'(cpu_stall), 32'd0);
        chk("after_gnt", 32'(ext_gnt), 32'd0);
        chk("after_ram_we", 32'(ram_we), 32'd1);
        chk("after_ram_addr", 32'(ram_addr), 32'h030);
        chk("after_ram_din", ram_din, 32'h77);
        pop_chk("force_wr");
        exp_mem[32'h030] = 32'h77;
        @(negedge clk);
        idle_all();
        ext_single("rd20", 1'b0, 10'h020, 32'h0);
        ext_single("rd30", 1'b0, 10'h030, 32'h0);

        // Out of range and range boundary (DEPTH = 512).
        ext_single("oor_wr", 1'b1, 10'h3FF, 32'hDEAD_BEEF);
        ext_single("oor_rd", 1'b0, 10'h200, 32'h0);
        ext_single("edge_wr", 1'b1, 10'h1FF, 32'h1234_5678);
        ext_single("edge_rd", 1'b0, 10'h1FF, 32'h0);

        // EXT withdraws during the forced slot.
        starve("drop", 10'h040, 32'h99);
        ext_req = 0;
        #1;
        chk("drop_stall", 32'(cpu_stall), 32'd1);
        chk("drop_gnt", 32'(ext_gnt), 32'd0);
        chk("drop_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        #1;
        chk("drop_rvalid", 32'(ext_rvalid), 32'd0);
        chk("drop_stall_off", 32'(cpu_stall), 32'd0);
        @(negedge clk);

        // Reset asserted in the middle of a forced slot.
        starve("rst", 10'h050, 32'hAA);
        #1;
        chk("rst_force_stall", 32'(cpu_stall), 32'd1);
        rst_n = 0;
        #1;
        chk("midrst_stall", 32'(cpu_stall), 32'd0);
        chk("midrst_ram_we", 32'(ram_we), 32'd0);
        chk("midrst_rvalid", 32'(ext_rvalid), 32'd0);
        chk("midrst_gnt", 32'(ext_gnt), 32'd0);
        chk("midrst_rdata", ext_rdata, 32'd0);
        @(negedge clk);
        idle_all();
        rst_n = 1;
        hold = '0;
        @(negedge clk);
        ext_single("post_rst_rd20", 1'b0, 10'h020, 32'h0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
